seq_decoder_3x8: RTL and testbench

SEQ_DECODER_3X8 -- requirements
Module: seq_decoder_3x8

---
 rtl/seq_decoder_3x8_pkg.sv | 14 +
 rtl/seq_decoder_3x8_if.sv | 22 ++
 rtl/seq_decoder_3x8_timer.sv | 41 ++++
 rtl/seq_decoder_3x8.sv | 116 +++++++++++
 tb/tb_seq_decoder_3x8.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/seq_decoder_3x8_pkg.sv
// Shared types and constants for the sequenced 3-to-8 decoder.
package dec_pkg;

  localparam int unsigned CNT_W         = 8;
  localparam int unsigned DEF_PULSE_LEN = 4;
  localparam int unsigned DEF_GAP_LEN   = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } dec_state_e;

endpackage

// File: rtl/seq_decoder_3x8_if.sv
// Code handshake and decoded-output bundle for seq_decoder_3x8.
interface seq_decoder_3x8_if;

  logic       e;
  logic       code_valid;
  logic [2:0] code_in;
  logic       code_ready;
  logic [7:0] y;
  logic       busy;
  logic       done;

  modport master (
    output e, code_valid, code_in,
    input  code_ready, y, busy, done
  );

  modport slave (
    input  e, code_valid, code_in,
    output code_ready, y, busy, done
  );

endinterface

// File: rtl/seq_decoder_3x8_timer.sv
// Loadable 8-bit down-counter that saturates at zero and flags the zero value.
module dec_timer
  import dec_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: a load wins over a decrement, and the count never goes below zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != {CNT_W{1'b0}})) begin
      cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == {CNT_W{1'b0}});

endmodule

// File: rtl/seq_decoder_3x8.sv
// Sequenced 3-to-8 decoder: each accepted code drives a one-hot pulse of
// PULSE_LEN cycles followed by GAP_LEN forced idle cycles.
module seq_decoder_3x8
  import dec_pkg::*;
#(
  parameter int unsigned PULSE_LEN = DEF_PULSE_LEN,
  parameter int unsigned GAP_LEN   = DEF_GAP_LEN
) (
  input  logic              clk,
  input  logic              rst,
  seq_decoder_3x8_if.slave  bus
);

  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_LEN - 32'd1);
  localparam logic [CNT_W-1:0] GAP_LOAD   =
    (GAP_LEN == 32'd0) ? {CNT_W{1'b0}} : CNT_W'(GAP_LEN - 32'd1);

  dec_state_e       state_q;
  dec_state_e       state_d;
  logic [7:0]       y_q;
  logic [7:0]       y_d;
  logic             load_s;
  logic [CNT_W-1:0] load_val_s;
  logic             dec_s;
  logic [CNT_W-1:0] cnt_s;
  logic             zero_s;
  logic             code_ready_s;
  logic             accept_s;

  assign code_ready_s = (state_q == IDLE) && bus.e && !rst;
  assign accept_s     = code_ready_s && bus.code_valid;

  dec_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load_s),
    .load_val_i (load_val_s),
    .dec_i      (dec_s),
    .cnt_o      (cnt_s),
    .zero_o     (zero_s)
  );

  // Next state, next output and counter control.
  always_comb begin
    state_d    = state_q;
    y_d        = y_q;
    load_s     = 1'b0;
    load_val_s = PULSE_LOAD;
    dec_s      = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d    = DRIVE;
          y_d        = 8'd1 << bus.code_in;
          load_s     = 1'b1;
          load_val_s = PULSE_LOAD;
        end else begin
          y_d = 8'd0;
        end
      end
      DRIVE: begin
        if (!bus.e) begin
          // Abort: drop the pulse and park the counter at zero.
          state_d    = IDLE;
          y_d        = 8'd0;
          load_s     = 1'b1;
          load_val_s = {CNT_W{1'b0}};
        end else if (zero_s) begin
          y_d = 8'd0;
          if (GAP_LEN == 32'd0) begin
            state_d = IDLE;
          end else begin
            state_d    = GAP;
            load_s     = 1'b1;
            load_val_s = GAP_LOAD;
          end
        end else begin
          dec_s = 1'b1;
        end
      end
      GAP: begin
        y_d = 8'd0;
        if (!bus.e) begin
          state_d    = IDLE;
          load_s     = 1'b1;
          load_val_s = {CNT_W{1'b0}};
        end else if (zero_s) begin
          state_d = IDLE;
        end else begin
          dec_s = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        y_d     = 8'd0;
      end
    endcase
  end

  // State and decoded-output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      y_q     <= 8'd0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
    end
  end

  assign bus.code_ready = code_ready_s;
  assign bus.y          = y_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = (state_q == DRIVE) && zero_s && bus.e;

endmodule

// File: tb/tb_seq_decoder_3x8.sv
// Directed scoreboard bench: default-parameter decoder plus a PULSE_LEN=1/GAP_LEN=0 instance.
module tb_seq_decoder_3x8;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [7:0] exp_q[$];

  seq_decoder_3x8_if bus0 ();
  seq_decoder_3x8_if bus1 ();

  seq_decoder_3x8 dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  seq_decoder_3x8 #(.PULSE_LEN(1), .GAP_LEN(0)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and check the per-cycle output invariants on both instances.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    chk("onehot0_d0", {31'd0, $onehot0(bus0.y)}, 32'd1);
    chk("zero_when_idle_d0", {31'd0, (bus0.busy || (bus0.y == 8'd0))}, 32'd1);
    chk("onehot0_d1", {31'd0, $onehot0(bus1.y)}, 32'd1);
    chk("zero_when_idle_d1", {31'd0, (bus1.busy || (bus1.y == 8'd0))}, 32'd1);
  endtask

  task automatic send_code(input logic [2:0] c);
    bus0.code_valid = 1'b1;
    bus0.code_in    = c;
    #1;
    chk("code_ready_at_send", {31'd0, bus0.code_ready}, 32'd1);
    exp_q.push_back(8'd1 << c);
    tick();
    bus0.code_valid = 1'b0;
  endtask

  task automatic pop_chk();
    logic [7:0] exp;
    chk("sb_nonempty", {31'd0, (exp_q.size() != 0)}, 32'd1);
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
    chk("y_loaded", {24'd0, bus0.y}, {24'd0, exp});
  endtask

  task automatic watch_pulse(input int exp_len, input int exp_gap);
    int len;
    int dones;
    int done_at;
    int gap;
    len = 0; dones = 0; done_at = 0; gap = 0;
    pop_chk();
    while ((bus0.y !== 8'd0) && (len < 300)) begin
      len++;
      if (bus0.done === 1'b1) begin
        dones++;
        done_at = len;
      end
      tick();
    end
    chk("pulse_len", len, exp_len);
    chk("done_count", dones, 32'd1);
    chk("done_last_cycle", done_at, exp_len);
    while ((bus0.busy === 1'b1) && (gap < 300)) begin
      gap++;
      tick();
    end
    chk("gap_len", gap, exp_gap);
    chk("ready_after_gap", {31'd0, bus0.code_ready}, 32'd1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    bus0.e = 1'b1; bus0.code_valid = 1'b0; bus0.code_in = 3'd0;
    bus1.e = 1'b0; bus1.code_valid = 1'b0; bus1.code_in = 3'd0;
    #1 rst = 1'b1;
    #1;
    chk("rst_y", {24'd0, bus0.y}, 32'd0);
    chk("rst_busy", {31'd0, bus0.busy}, 32'd0);
    chk("rst_done", {31'd0, bus0.done}, 32'd0);
    chk("rst_ready_forced", {31'd0, bus0.code_ready}, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("ready_after_rst", {31'd0, bus0.code_ready}, 32'd1);

    // Codes 0..7 enabled: 4-cycle pulses, one done each, 1 gap cycle.
    for (int c = 0; c < 8; c++) begin
      send_code(3'(c));
      watch_pulse(4, 1);
    end

    // Same codes with the decoder disabled.
    bus0.e = 1'b0;
    for (int c = 0; c < 8; c++) begin
      bus0.code_valid = 1'b1;
      bus0.code_in    = 3'(c);
      #1;
      chk("dis_ready", {31'd0, bus0.code_ready}, 32'd0);
      tick();
      chk("dis_y", {24'd0, bus0.y}, 32'd0);
      chk("dis_done", {31'd0, bus0.done}, 32'd0);
      chk("dis_busy", {31'd0, bus0.busy}, 32'd0);
    end
    bus0.code_valid = 1'b0;
    bus0.e = 1'b1;
    tick();

    // Code 5, enable dropped on the 2nd DRIVE cycle.
    send_code(3'd5);
    pop_chk();
    tick();
    bus0.e = 1'b0;
    #1;
    chk("abort_no_done", {31'd0, bus0.done}, 32'd0);
    tick();
    chk("abort_y", {24'd0, bus0.y}, 32'd0);
    chk("abort_idle", {31'd0, bus0.busy}, 32'd0);
    chk("abort_done", {31'd0, bus0.done}, 32'd0);
    bus0.e = 1'b1;
    tick();

    // Code 3, reset asserted between edges on the 3rd DRIVE cycle.
    send_code(3'd3);
    pop_chk();
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_y", {24'd0, bus0.y}, 32'd0);
    chk("rst_mid_busy", {31'd0, bus0.busy}, 32'd0);
    chk("rst_mid_done", {31'd0, bus0.done}, 32'd0);
    chk("rst_mid_ready", {31'd0, bus0.code_ready}, 32'd0);
    tick();
    rst = 1'b0;
    send_code(3'd6);
    watch_pulse(4, 1);

    // PULSE_LEN=1, GAP_LEN=0 with code 2 held valid.
    bus1.e = 1'b1;
    bus1.code_valid = 1'b1;
    bus1.code_in = 3'd2;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("b2b_y", {24'd0, bus1.y}, ((i % 2) == 0) ? 32'h4 : 32'h0);
      chk("b2b_done", {31'd0, bus1.done}, ((i % 2) == 0) ? 32'd1 : 32'd0);
    end
    bus1.code_valid = 1'b0;
    tick();
    tick();
    chk("sb_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
